// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus a carry flop, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ps_q, ps_d, sum_q, sum_d, ps_sh;
  logic [WIDTH:0] ps_cat;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, s_bit, c_new;
  assign s_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
  assign c_new  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  // {s_bit, ps[WIDTH-1:1]} written so it stays legal when WIDTH is 1
  assign ps_cat = {s_bit, ps_q};
  assign ps_sh  = ps_cat[WIDTH:1];
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == SHIFT) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      ps_d  = ps_sh;
      c_d   = c_new;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        sum_d   = ps_sh;
        cout_d  = c_new;
        state_d = DONE;
      end
    end else if (start_i) begin
      sa_d    = a_i;
      sb_d    = b_i;
      c_d     = cin_i;
      ps_d    = '0;
      cnt_d   = '0;
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy_o = state_q == SHIFT;
  assign done_o = state_q == DONE;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk, rst_n;
  logic start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  int checks, failures;
  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
  );
  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
    .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    a8 = a;
    b8 = b;
    cin8 = ci;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [8:0] exp, input string tag);
    start_op8(a, b, ci);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), {30'd0, busy8, done8}, 32'h2);
      @(negedge clk);
    end
    chk($sformatf("%s_done", tag), {30'd0, busy8, done8}, 32'h1);
    chk($sformatf("%s_res", tag), {23'd0, cout8, sum8}, {23'd0, exp});
  endtask
  initial begin
    logic [7:0] ra, rb;
    logic rc;
    int saw;
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_flags", {30'd0, busy8, done8}, 32'h0);
    chk("rst_res", {23'd0, cout8, sum8}, 32'h0);
    #8 rst_n = 1'b1;
    run8(8'h5A, 8'h3C, 1'b0, 9'h096, "basic");
    @(negedge clk);
    chk("basic_idle_flags", {30'd0, busy8, done8}, 32'h0);
    chk("basic_idle_hold", {23'd0, cout8, sum8}, 32'h096);
    run8(8'hFF, 8'h01, 1'b0, 9'h100, "carry_ff01");
    run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "carry_ffff1");
    run8(8'h00, 8'h00, 1'b1, 9'h001, "carry_0001");
    start_op8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ign_busy", {30'd0, busy8, done8}, 32'h2);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("ign_done", {30'd0, busy8, done8}, 32'h1);
    chk("ign_res", {23'd0, cout8, sum8}, 32'h030);
    a8 = 8'h01;
    b8 = 8'h02;
    cin8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy_now", {30'd0, busy8, done8}, 32'h2);
    chk("b2b_hold", {23'd0, cout8, sum8}, 32'h030);
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("b2b_still_busy", {30'd0, busy8, done8}, 32'h2);
    @(negedge clk);
    chk("b2b_done", {30'd0, busy8, done8}, 32'h1);
    chk("b2b_res", {23'd0, cout8, sum8}, 32'h003);
    start_op8(8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {30'd0, busy8, done8}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {30'd0, busy8, done8}, 32'h0);
    chk("mid_rst_res", {23'd0, cout8, sum8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) saw++;
    end
    chk("mid_no_done", saw, 0);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] e;
      e = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      @(negedge clk);
      a1 = i[2];
      b1 = i[1];
      cin1 = i[0];
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk($sformatf("w1_busy%0d", i), {30'd0, busy1, done1}, 32'h2);
      @(negedge clk);
      chk($sformatf("w1_done%0d", i), {30'd0, busy1, done1}, 32'h1);
      chk($sformatf("w1_res%0d", i), {30'd0, cout1, sum1}, {30'd0, e});
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc), $sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
